// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: steps one instruction through FETCH..WRITEBACK and drives the stage bus.
// Latency: 6 cycles per instruction with single-cycle acks (2 FETCH, DECODE, OPERAND, EXECUTE, WRITEBACK); MEMORY adds >=1.
// Backpressure: requests are held until the matching ack; a stalled ack times out into a sticky FAULT state.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   run_i               fetch enable, only sampled in FETCH before the request goes out
//   itype_i             decoded instruction class (codes below)
//   branch_taken_i      branch condition, sampled in WRITEBACK
//   alu_y_i             alu result, used as the taken-branch target
//   imem_ack_i          instruction memory data valid
//   dmem_ack_i          data memory access complete
//   stage_o             current stage (0..5 normal flow, 7 FAULT)
//   pc_o, retired_o     program counter, retired instruction count
//   imem_req_o, ir_load_o                   fetch handshake and instruction latch pulse
//   readin_a_o, readin_b_o, readin_pass_o   alu operand-latch strobes
//   dmem_req_o, dmem_we_o                   data memory handshake
//   rf_we_o             register-file write enable
//   fault_o             sticky fault flag
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic [4:0]  itype_i,
  input  logic        branch_taken_i,
  input  logic [31:0] alu_y_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  output logic [2:0]  stage_o,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic        ir_load_o,
  output logic        readin_a_o,
  output logic        readin_b_o,
  output logic        readin_pass_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        rf_we_o,
  output logic [31:0] retired_o,
  output logic        fault_o
);

  // Instruction class codes produced by the decoder; anything above LTYPE is illegal.
  localparam logic [4:0] RTYPE = 5'd0;
  localparam logic [4:0] ITYPE = 5'd1;
  localparam logic [4:0] STYPE = 5'd2;
  localparam logic [4:0] BTYPE = 5'd3;
  localparam logic [4:0] UTYPE = 5'd4;
  localparam logic [4:0] LTYPE = 5'd5;

  // Encoding is visible on stage_o; the alu keys its compute on EXECUTE == 3.
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_OPERAND   = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd7
  } stage_e;

  stage_e      r_stage, w_nxt_stage;
  logic [31:0] r_pc, w_nxt_pc;
  logic [31:0] r_retired, w_nxt_retired;
  logic [7:0]  r_cnt, w_nxt_cnt;
  logic [4:0]  r_itype, w_nxt_itype;
  logic        r_imem_req, w_nxt_imem_req;
  logic        r_ir_load, w_nxt_ir_load;
  logic        r_readin, w_nxt_readin;
  logic        r_dmem_req, w_nxt_dmem_req;
  logic        r_dmem_we, w_nxt_dmem_we;
  logic        r_rf_we, w_nxt_rf_we;
  logic        r_fault, w_nxt_fault;
  logic        w_cnt_hit;

  assign w_cnt_hit = (r_cnt == MEM_TIMEOUT);

  always_comb begin
    w_nxt_stage    = r_stage;
    w_nxt_pc       = r_pc;
    w_nxt_retired  = r_retired;
    w_nxt_cnt      = r_cnt;
    w_nxt_itype    = r_itype;
    w_nxt_imem_req = 1'b0;
    w_nxt_ir_load  = 1'b0;
    w_nxt_readin   = 1'b0;
    w_nxt_dmem_req = 1'b0;
    w_nxt_dmem_we  = 1'b0;
    w_nxt_rf_we    = 1'b0;
    w_nxt_fault    = r_fault;

    case (r_stage)
      S_FETCH: begin
        // Once the request is out, run_i no longer matters; only ack or timeout moves us.
        if (r_imem_req) begin
          if (imem_ack_i) begin
            w_nxt_stage   = S_DECODE;
            w_nxt_ir_load = 1'b1;
          end else if (w_cnt_hit) begin
            w_nxt_stage = S_FAULT;
            w_nxt_fault = 1'b1;
          end else begin
            w_nxt_imem_req = 1'b1;
            w_nxt_cnt      = r_cnt + 8'd1;
          end
        end else if (run_i) begin
          w_nxt_imem_req = 1'b1;
        end
      end

      S_DECODE: begin
        // Class is captured here so later stages do not depend on the decoder holding it.
        if (itype_i > LTYPE) begin
          w_nxt_stage = S_FAULT;
          w_nxt_fault = 1'b1;
        end else begin
          w_nxt_stage  = S_OPERAND;
          w_nxt_itype  = itype_i;
          w_nxt_readin = 1'b1;
        end
      end

      S_OPERAND: w_nxt_stage = S_EXECUTE;

      S_EXECUTE: begin
        if ((r_itype == STYPE) || (r_itype == LTYPE)) begin
          w_nxt_stage    = S_MEMORY;
          w_nxt_dmem_req = 1'b1;
          w_nxt_dmem_we  = (r_itype == STYPE);
          w_nxt_cnt      = 8'd0;
        end else begin
          w_nxt_stage = S_WRITEBACK;
          w_nxt_rf_we = (r_itype != BTYPE);
        end
      end

      S_MEMORY: begin
        // An ack arriving on the timeout cycle still counts as normal completion.
        if (dmem_ack_i) begin
          w_nxt_stage = S_WRITEBACK;
          w_nxt_rf_we = (r_itype == LTYPE);
        end else if (w_cnt_hit) begin
          w_nxt_stage = S_FAULT;
          w_nxt_fault = 1'b1;
        end else begin
          w_nxt_dmem_req = 1'b1;
          w_nxt_dmem_we  = r_dmem_we;
          w_nxt_cnt      = r_cnt + 8'd1;
        end
      end

      S_WRITEBACK: begin
        w_nxt_stage   = S_FETCH;
        w_nxt_cnt     = 8'd0;
        w_nxt_retired = r_retired + 32'd1;
        w_nxt_pc      = ((r_itype == BTYPE) && branch_taken_i) ? alu_y_i : (r_pc + 32'd4);
      end

      S_FAULT: w_nxt_fault = 1'b1;

      // The unused encoding is treated as corruption and parks in FAULT.
      default: begin
        w_nxt_stage = S_FAULT;
        w_nxt_fault = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_retired  <= 32'd0;
      r_cnt      <= 8'd0;
      r_itype    <= RTYPE;
      r_imem_req <= 1'b0;
      r_ir_load  <= 1'b0;
      r_readin   <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_stage    <= w_nxt_stage;
      r_pc       <= w_nxt_pc;
      r_retired  <= w_nxt_retired;
      r_cnt      <= w_nxt_cnt;
      r_itype    <= w_nxt_itype;
      r_imem_req <= w_nxt_imem_req;
      r_ir_load  <= w_nxt_ir_load;
      r_readin   <= w_nxt_readin;
      r_dmem_req <= w_nxt_dmem_req;
      r_dmem_we  <= w_nxt_dmem_we;
      r_rf_we    <= w_nxt_rf_we;
      r_fault    <= w_nxt_fault;
    end
  end

  assign stage_o       = r_stage;
  assign pc_o          = r_pc;
  assign retired_o     = r_retired;
  assign imem_req_o    = r_imem_req;
  assign ir_load_o     = r_ir_load;
  assign readin_a_o    = r_readin;
  assign readin_b_o    = r_readin;
  assign readin_pass_o = r_readin;
  assign dmem_req_o    = r_dmem_req;
  assign dmem_we_o     = r_dmem_we;
  assign rf_we_o       = r_rf_we;
  assign fault_o       = r_fault;

  // Keep the unused class codes referenced so the table above stays complete.
  logic w_unused;
  assign w_unused = ^{ITYPE, UTYPE};

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus pushes expected events, monitor pops on reset/retire/fault.
// Latency: n/a (bench).
// Backpressure: memory responders ack after a programmable number of request cycles, or never.
module tb_core_sequencer;
  localparam logic [4:0] C_R = 5'd0, C_I = 5'd1, C_S = 5'd2, C_B = 5'd3, C_U = 5'd4, C_L = 5'd5;
  localparam int K_RST = 0, K_RET = 1, K_FLT = 2;

  logic        clk = 1'b0, reset = 1'b1, run_i = 1'b0;
  logic [4:0]  itype_i = C_R;
  logic        branch_taken_i = 1'b0;
  logic [31:0] alu_y_i = 32'd0;
  logic        imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
  logic [2:0]  stage_o;
  logic [31:0] pc_o, retired_o;
  logic        imem_req_o, ir_load_o, readin_a_o, readin_b_o, readin_pass_o;
  logic        dmem_req_o, dmem_we_o, rf_we_o, fault_o;

  core_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .itype_i(itype_i),
    .branch_taken_i(branch_taken_i), .alu_y_i(alu_y_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .stage_o(stage_o), .pc_o(pc_o), .imem_req_o(imem_req_o), .ir_load_o(ir_load_o),
    .readin_a_o(readin_a_o), .readin_b_o(readin_b_o), .readin_pass_o(readin_pass_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .rf_we_o(rf_we_o),
    .retired_o(retired_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] ret;
    int          ireq, dreq, dwe, rf, rd;
    logic [23:0] trace;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, ev_cnt = 0, ev_target = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responders: imem acks on the first request cycle; dmem acks on request cycle dmem_delay+1.
  bit imem_en = 1'b1, dmem_en = 1'b1;
  int dmem_delay = 0, dcnt = 0;
  always @(posedge clk) begin
    #2;
    imem_ack_i = imem_en && imem_req_o;
    if (dmem_req_o) begin
      dcnt++;
      dmem_ack_i = dmem_en && (dcnt == dmem_delay + 1);
    end else begin
      dcnt = 0;
      dmem_ack_i = 1'b0;
    end
  end

  // Monitor state, sampled on the falling edge.
  bit          rst_s = 1'b0, rst_prev = 1'b0;
  int          ireq_n = 0, dreq_n = 0, dwe_n = 0, rf_n = 0, rd_any = 0, rd_good = 0, bad_fault = 0;
  logic [2:0]  last_stage = 3'd0;
  logic [23:0] trace = 24'd0;
  logic [31:0] f_pc = 0, f_ret = 0;

  always @(posedge clk) rst_s = reset;

  task automatic clear_stats();
    ireq_n = 0; dreq_n = 0; dwe_n = 0; rf_n = 0; rd_any = 0; rd_good = 0;
    trace = 24'd0;
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
      return;
    end
    e = q.pop_front();
    ev_cnt++;
    chk("event_kind", 32'(kind), 32'(e.kind));
    chk("pc", pc_o, e.pc);
    chk("retired", retired_o, e.ret);
    if (e.kind == K_RST) begin
      chk("rst_stage", 32'(stage_o), 32'd0);
      chk("rst_outs", 32'({imem_req_o, ir_load_o, readin_a_o, readin_b_o, readin_pass_o,
                            dmem_req_o, dmem_we_o, rf_we_o, fault_o}), 32'd0);
      chk("fault_hold_violations", 32'(bad_fault), 32'd0);
    end else begin
      chk("fault_flag", 32'(fault_o), (e.kind == K_FLT) ? 32'd1 : 32'd0);
      chk("imem_req_cycles", 32'(ireq_n), 32'(e.ireq));
      chk("dmem_req_cycles", 32'(dreq_n), 32'(e.dreq));
      chk("dmem_we_cycles", 32'(dwe_n), 32'(e.dwe));
      chk("stage_trace", 32'(trace), 32'(e.trace));
      if (e.kind == K_RET) begin
        chk("rf_we_cycles", 32'(rf_n), 32'(e.rf));
        chk("readin_any_cycles", 32'(rd_any), 32'(e.rd));
        chk("readin_all_in_operand", 32'(rd_good), 32'(e.rd));
      end else begin
        chk("fault_outs", 32'({imem_req_o, dmem_req_o, rf_we_o, readin_a_o}), 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_s) begin
      if (!rst_prev) pop_check(K_RST);
      clear_stats();
      bad_fault = 0;
      last_stage = 3'd0;
    end else begin
      ireq_n += imem_req_o ? 1 : 0;
      dreq_n += dmem_req_o ? 1 : 0;
      dwe_n  += dmem_we_o ? 1 : 0;
      rf_n   += rf_we_o ? 1 : 0;
      rd_any += (readin_a_o || readin_b_o || readin_pass_o) ? 1 : 0;
      rd_good += (readin_a_o && readin_b_o && readin_pass_o && stage_o == 3'd2) ? 1 : 0;
      if (stage_o != last_stage) trace = {trace[20:0], stage_o};
      if (stage_o == 3'd0 && last_stage == 3'd5) begin
        pop_check(K_RET);
        clear_stats();
      end else if (stage_o == 3'd7 && last_stage != 3'd7) begin
        pop_check(K_FLT);
        f_pc = pc_o;
        f_ret = retired_o;
      end else if (stage_o == 3'd7) begin
        if (!fault_o || imem_req_o || dmem_req_o || rf_we_o || ir_load_o || readin_a_o ||
            pc_o != f_pc || retired_o != f_ret) bad_fault++;
      end
      last_stage = stage_o;
    end
    rst_prev = rst_s;
  end

  // Stimulus side.
  logic [31:0] exp_pc = 32'd0, exp_ret = 32'd0;

  task automatic wait_ev();
    for (int i = 0; i < 300; i++) begin
      if (ev_cnt >= ev_target) return;
      @(posedge clk); #2;
    end
    checks++; failures++;
    $display("FAIL event_timeout: got %0d events expected %0d", ev_cnt, ev_target);
    q.delete();
    ev_cnt = ev_target;
  endtask

  task automatic push_rst();
    exp_t e;
    e = '{kind: K_RST, pc: 32'h0, ret: 32'd0, ireq: 0, dreq: 0, dwe: 0, rf: 0, rd: 0, trace: 24'd0};
    q.push_back(e);
    ev_target++;
  endtask

  task automatic do_reset();
    push_rst();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    exp_pc = 32'd0;
    exp_ret = 32'd0;
    wait_ev();
  endtask

  task automatic instr(input logic [4:0] it, input logic tk, input logic [31:0] y, input int dly);
    exp_t e;
    bit mem;
    mem = (it == C_S) || (it == C_L);
    exp_pc = (it == C_B && tk) ? y : exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    e = '{kind: K_RET, pc: exp_pc, ret: exp_ret, ireq: 1,
          dreq: mem ? dly + 1 : 0, dwe: (it == C_S) ? dly + 1 : 0,
          rf: (it == C_S || it == C_B) ? 0 : 1, rd: 1,
          trace: mem ? 24'o123450 : 24'o12350};
    q.push_back(e);
    ev_target++;
    itype_i = it; branch_taken_i = tk; alu_y_i = y; dmem_delay = dly;
    wait_ev();
  endtask

  task automatic expect_fault(input int ireq, input int dreq, input int dwe, input logic [23:0] tr);
    exp_t e;
    e = '{kind: K_FLT, pc: exp_pc, ret: exp_ret, ireq: ireq, dreq: dreq, dwe: dwe,
          rf: 0, rd: 0, trace: tr};
    q.push_back(e);
    ev_target++;
  endtask

  initial begin
    push_rst();
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    wait_ev();
    repeat (5) @(posedge clk);  // run_i low: no fetch request may appear
    #2 run_i = 1'b1;

    instr(C_R, 1'b0, 32'h0, 0);            // pc 4
    instr(C_B, 1'b1, 32'h40, 0);           // taken -> 0x40
    instr(C_B, 1'b0, 32'h80, 0);           // not taken -> 0x44
    instr(C_S, 1'b0, 32'h0, 3);            // store, 4 req cycles
    instr(C_L, 1'b0, 32'h0, 3);            // load, 4 req cycles
    instr(C_L, 1'b0, 32'h0, 4);            // ack on timeout cycle still completes
    instr(C_I, 1'b0, 32'h0, 0);
    instr(C_U, 1'b0, 32'h0, 0);
    instr(C_B, 1'b1, 32'hFFFF_FFFC, 0);
    instr(C_R, 1'b0, 32'h0, 0);            // wraps to 0

    // Reset while a data request is outstanding.
    dmem_en = 1'b0; itype_i = C_L;
    for (int i = 0; i < 50 && stage_o != 3'd4; i++) begin @(posedge clk); #2; end
    chk("reach_memory", 32'(dmem_req_o), 32'd1);
    do_reset();

    // Data memory never acks on a store -> timeout fault.
    itype_i = C_S;
    expect_fault(1, 5, 5, 24'o12347);
    wait_ev();
    repeat (6) begin @(posedge clk); #2 run_i = ~run_i; end
    run_i = 1'b1; dmem_en = 1'b1; imem_en = 1'b0;
    do_reset();

    // Instruction memory never acks -> timeout after 5 request cycles.
    expect_fault(5, 0, 0, 24'o7);
    wait_ev();
    repeat (4) @(posedge clk);
    #2 imem_en = 1'b1; itype_i = 5'h1F;
    do_reset();

    // Illegal instruction class.
    expect_fault(1, 0, 0, 24'o17);
    wait_ev();
    repeat (3) @(posedge clk);
    #2 itype_i = C_R;
    do_reset();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
